// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with prefetch FIFO, jump redirect and HALT stop
//
// Walks a program counter and reads instruction memory over a single-outstanding
// req/ack handshake. Fetched words are queued with their addresses and offered
// downstream on a valid/ready handshake.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 pulse: leave IDLE/HALTED and fetch from current PC
//   jump_en, jump_addr    redirect: flush queue, discard in-flight read, refetch at target
//   mem_req, mem_addr     registered read request, held until mem_ack
//   mem_ack, mem_rdata    read completion and data
//   instruction, instr_pc head word and its address
//   instr_valid           queue non-empty
//   instr_ready           consumer takes the head word
//   halted                HALT opcode (4'hF) fetched, fetching stopped
//   busy                  state is FETCH
//   fetch_stall_cnt       (FETCH_PERF_CNT_EN only) saturating count of cycles the
//                         consumer was ready but nothing was valid while fetching
//
// Build option: define FETCH_PERF_CNT_EN to add fetch_stall_cnt.

module instr_fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              discard;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic ack_taken;
  logic push;
  logic pop;
  logic halt_hit;
  logic pending_nxt;
  logic issue;

  assign instr_valid = (count != '0);
  assign instruction = fifo_data[rd_ptr];
  assign instr_pc    = fifo_addr[rd_ptr];
  assign busy        = (state == S_FETCH);

  always_comb begin
    ack_taken   = mem_req & mem_ack;
    // Data returning for a pre-jump address (or in the jump cycle itself) is dropped.
    push        = ack_taken & ~discard & ~jump_en;
    pop         = instr_valid & instr_ready;
    halt_hit    = push & (mem_rdata[DATA_W-1 -: 4] == 4'hF);
    pending_nxt = mem_req & ~mem_ack;

    state_nxt = state;
    if (jump_en) begin
      state_nxt = (state == S_IDLE) ? S_IDLE : S_FETCH;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_FETCH;
        S_FETCH:  if (halt_hit) state_nxt = S_HALTED;
        S_HALTED: if (start) state_nxt = S_FETCH;
        default:  state_nxt = S_IDLE;
      endcase
    end

    pc_nxt = pc;
    if (jump_en)   pc_nxt = jump_addr;
    else if (push) pc_nxt = pc + 1'b1;

    count_nxt = count;
    if (jump_en) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end

    // Issuing against post-push/pop occupancy lets a full queue refill in the
    // same cycle it is popped, giving one word per cycle at zero wait.
    issue = (state_nxt == S_FETCH) & ~halt_hit &
            (count_nxt < CNT_W'(FIFO_DEPTH)) & ~pending_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      discard  <= 1'b0;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      count   <= count_nxt;
      halted  <= (state_nxt == S_HALTED);
      mem_req <= issue | pending_nxt;
      if (issue) mem_addr <= pc_nxt;

      // A jump cannot cancel a read already on the bus; mark it so its data is dropped.
      if (jump_en & pending_nxt) discard <= 1'b1;
      else if (ack_taken)        discard <= 1'b0;

      if (jump_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= mem_rdata;
          fifo_addr[wr_ptr] <= mem_addr;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_stall_cnt <= '0;
    end else if (jump_en) begin
      fetch_stall_cnt <= '0;
    end else if ((state == S_FETCH) && instr_ready && !instr_valid &&
                 (fetch_stall_cnt != 16'hFFFF)) begin
      fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
